// File: rtl/fft_pkg.sv
// Shared constants and helpers for the FFT datapath blocks.
package fft_pkg;

    localparam int unsigned DefDataW = 16;
    localparam int unsigned DefFracW = 8;

    // Side-band flags that travel with each butterfly transaction.
    typedef struct packed {
        logic inverse;
        logic scale;
    } bf_flags_t;

    // Half-LSB constant for round-half-up before dropping frac_w bits.
    function automatic longint round_const(input int unsigned frac_w);
        if (frac_w == 0) begin
            return longint'(0);
        end
        return longint'(1) << (frac_w - 1);
    endfunction

endpackage

// File: rtl/cmplx_mult.sv
// Two-stage pipelined complex multiplier T = W*B (or conj(W)*B).
// Operand A and the per-transaction flags are carried alongside.
module cmplx_mult
    import fft_pkg::*;
#(
    parameter int unsigned DATA_W = DefDataW,
    parameter int unsigned FRAC_W = DefFracW
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              en,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] a_re,
    input  logic [DATA_W-1:0] a_im,
    input  logic [DATA_W-1:0] b_re,
    input  logic [DATA_W-1:0] b_im,
    input  logic [DATA_W-1:0] w_re,
    input  logic [DATA_W-1:0] w_im,
    input  logic              inverse,
    input  logic              scale,
    output logic              valid_s2,
    output logic [DATA_W-1:0] a_re_s2,
    output logic [DATA_W-1:0] a_im_s2,
    output logic [DATA_W+1:0] t_re,
    output logic [DATA_W+1:0] t_im,
    output logic              inverse_s2,
    output logic              scale_s2
);

    localparam int unsigned PW = 2 * DATA_W;
    localparam int unsigned SW = 2 * DATA_W + 1;
    localparam int unsigned TW = DATA_W + 2;
    localparam logic signed [SW-1:0] Rnd = SW'(round_const(FRAC_W));

    logic                     valid_s1;
    logic signed [PW-1:0]     p_rr, p_ii, p_ri, p_ir;
    logic [DATA_W-1:0]        a_re_s1, a_im_s1;
    bf_flags_t                flags_s1;
    logic signed [SW-1:0]     sum_re, sum_im;
    logic [TW-1:0]            t_re_d, t_im_d;

    // S1: the four full-width partial products.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            valid_s1 <= 1'b0;
            p_rr     <= '0;
            p_ii     <= '0;
            p_ri     <= '0;
            p_ir     <= '0;
            a_re_s1  <= '0;
            a_im_s1  <= '0;
            flags_s1 <= '0;
        end else if (en) begin
            valid_s1 <= in_valid;
            p_rr     <= PW'($signed(w_re)) * PW'($signed(b_re));
            p_ii     <= PW'($signed(w_im)) * PW'($signed(b_im));
            p_ri     <= PW'($signed(w_re)) * PW'($signed(b_im));
            p_ir     <= PW'($signed(w_im)) * PW'($signed(b_re));
            a_re_s1  <= a_re;
            a_im_s1  <= a_im;
            flags_s1 <= '{inverse: inverse, scale: scale};
        end
    end

    // S2 combine: conj(W) flips the sign of every w_im term; then round half-up.
    always_comb begin
        if (flags_s1.inverse) begin
            sum_re = SW'(p_rr) + SW'(p_ii);
            sum_im = SW'(p_ri) - SW'(p_ir);
        end else begin
            sum_re = SW'(p_rr) - SW'(p_ii);
            sum_im = SW'(p_ri) + SW'(p_ir);
        end
        t_re_d = TW'((sum_re + Rnd) >>> FRAC_W);
        t_im_d = TW'((sum_im + Rnd) >>> FRAC_W);
    end

    // S2 register: rounded product plus carried operand and flags.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            valid_s2   <= 1'b0;
            t_re       <= '0;
            t_im       <= '0;
            a_re_s2    <= '0;
            a_im_s2    <= '0;
            inverse_s2 <= 1'b0;
            scale_s2   <= 1'b0;
        end else if (en) begin
            valid_s2   <= valid_s1;
            t_re       <= t_re_d;
            t_im       <= t_im_d;
            a_re_s2    <= a_re_s1;
            a_im_s2    <= a_im_s1;
            inverse_s2 <= flags_s1.inverse;
            scale_s2   <= flags_s1.scale;
        end
    end

endmodule

// File: rtl/butterfly_pipe.sv
// Three-stage radix-2 butterfly: Y1 = A + W*B, Y2 = A - W*B, with a global
// stall on output back-pressure. Define BUTTERFLY_SAT_EN to saturate
// out-of-range results instead of wrapping them.
module butterfly_pipe
    import fft_pkg::*;
#(
    parameter int unsigned DATA_W = DefDataW,
    parameter int unsigned FRAC_W = DefFracW
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] a_re,
    input  logic [DATA_W-1:0] a_im,
    input  logic [DATA_W-1:0] b_re,
    input  logic [DATA_W-1:0] b_im,
    input  logic [DATA_W-1:0] w_re,
    input  logic [DATA_W-1:0] w_im,
    input  logic              inverse,
    input  logic              scale,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] y1_re,
    output logic [DATA_W-1:0] y1_im,
    output logic [DATA_W-1:0] y2_re,
    output logic [DATA_W-1:0] y2_im,
    output logic              ovf,
    input  logic              ovf_clr
);

    localparam int unsigned TW = DATA_W + 2;
`ifdef BUTTERFLY_SAT_EN
    localparam logic [DATA_W-1:0] MaxPos = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] MaxNeg = {1'b1, {(DATA_W-1){1'b0}}};
`endif

    logic                 en;
    logic                 valid_s2, inverse_s2, scale_s2;
    logic [DATA_W-1:0]    a_re_s2, a_im_s2;
    logic signed [TW-1:0] t_re, t_im;
    logic signed [TW-1:0] a_re_x, a_im_x;
    logic signed [TW-1:0] res [4];
    logic [DATA_W-1:0]    red [4];
    logic [3:0]           oor;

    // Whole pipe freezes while a result waits for the consumer.
    assign en       = !(out_valid && !out_ready);
    assign in_ready = en;

    cmplx_mult #(
        .DATA_W (DATA_W),
        .FRAC_W (FRAC_W)
    ) u_mult (
        .clk        (clk),
        .n_rst      (n_rst),
        .en         (en),
        .in_valid   (in_valid),
        .a_re       (a_re),
        .a_im       (a_im),
        .b_re       (b_re),
        .b_im       (b_im),
        .w_re       (w_re),
        .w_im       (w_im),
        .inverse    (inverse),
        .scale      (scale),
        .valid_s2   (valid_s2),
        .a_re_s2    (a_re_s2),
        .a_im_s2    (a_im_s2),
        .t_re       (t_re),
        .t_im       (t_im),
        .inverse_s2 (inverse_s2),
        .scale_s2   (scale_s2)
    );

    // S3 combine: add/sub, optional halve, then range-reduce to DATA_W.
    always_comb begin
        a_re_x = TW'($signed(a_re_s2));
        a_im_x = TW'($signed(a_im_s2));
        res[0] = a_re_x + t_re;
        res[1] = a_im_x + t_im;
        res[2] = a_re_x - t_re;
        res[3] = a_im_x - t_im;
        oor    = '0;
        for (int i = 0; i < 4; i++) begin
            if (scale_s2) begin
                res[i] = res[i] >>> 1;
            end
            // In range only if the bits above the DATA_W sign bit all match it.
            oor[i] = (res[i][TW-1:DATA_W-1] != '0) && (res[i][TW-1:DATA_W-1] != '1);
`ifdef BUTTERFLY_SAT_EN
            red[i] = oor[i] ? (res[i][TW-1] ? MaxNeg : MaxPos) : res[i][DATA_W-1:0];
`else
            red[i] = res[i][DATA_W-1:0];
`endif
        end
    end

    // S3 output register, held while stalled.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            out_valid <= 1'b0;
            y1_re     <= '0;
            y1_im     <= '0;
            y2_re     <= '0;
            y2_im     <= '0;
        end else if (en) begin
            out_valid <= valid_s2;
            y1_re     <= red[0];
            y1_im     <= red[1];
            y2_re     <= red[2];
            y2_im     <= red[3];
        end
    end

    // Sticky overflow: a new overflow wins over a same-cycle clear.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            ovf <= 1'b0;
        end else if (en && valid_s2 && (oor != '0)) begin
            ovf <= 1'b1;
        end else if (ovf_clr) begin
            ovf <= 1'b0;
        end
    end

endmodule

// File: tb/tb_butterfly_pipe.sv
// Directed self-checking bench for butterfly_pipe (Q8.8).
module tb_butterfly_pipe;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        in_valid, in_ready;
    logic [15:0] a_re, a_im, b_re, b_im, w_re, w_im;
    logic        inverse, scale;
    logic        out_valid, out_ready;
    logic [15:0] y1_re, y1_im, y2_re, y2_im;
    logic        ovf, ovf_clr;

    int          n_checks = 0;
    int          n_errors = 0;
    int          lat;
    logic [15:0] g1r, g1i, g2r, g2i;
    logic [15:0] exp_ovf_re;

    int          acc, got, stalls, stale;
    logic        stall_prev;
    logic [15:0] prev1, prev2;

    butterfly_pipe #(
        .DATA_W (16),
        .FRAC_W (8)
    ) dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_re      (a_re),
        .a_im      (a_im),
        .b_re      (b_re),
        .b_im      (b_im),
        .w_re      (w_re),
        .w_im      (w_im),
        .inverse   (inverse),
        .scale     (scale),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y1_re     (y1_re),
        .y1_im     (y1_im),
        .y2_re     (y2_re),
        .y2_im     (y2_im),
        .ovf       (ovf),
        .ovf_clr   (ovf_clr)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input logic [15:0] ar, ai, br, bi, wr, wi, input logic inv, scl);
        a_re = ar; a_im = ai; b_re = br; b_im = bi; w_re = wr; w_im = wi;
        inverse = inv; scale = scl;
    endtask

    // Issue one transaction, wait (bounded) for its result and capture it.
    task automatic send_one(input logic [15:0] ar, ai, br, bi, wr, wi, input logic inv, scl);
        int guard;
        @(negedge clk);
        set_in(ar, ai, br, bi, wr, wi, inv, scl);
        in_valid = 1'b1;
        guard = 0;
        while (!in_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        check_eq("result_valid", out_valid, 1);
        g1r = y1_re; g1i = y1_im; g2r = y2_re; g2i = y2_im;
    endtask

    task automatic check_y(input string tag, input logic [15:0] e1r, e1i, e2r, e2i);
        check_eq({tag, "_y1re"}, g1r, e1r);
        check_eq({tag, "_y1im"}, g1i, e1i);
        check_eq({tag, "_y2re"}, g2r, e2r);
        check_eq({tag, "_y2im"}, g2i, e2i);
    endtask

    initial begin
        n_rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1; ovf_clr = 1'b0;
        set_in(16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0);
`ifdef BUTTERFLY_SAT_EN
        exp_ovf_re = 16'h7FFF;
`else
        exp_ovf_re = 16'hFE00;
`endif
        #12;
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_y1re", y1_re, 0);
        check_eq("rst_y2im", y2_im, 0);
        check_eq("rst_ovf", ovf, 0);
        @(negedge clk);
        n_rst = 1'b1;
        #1;
        check_eq("rst_in_ready", in_ready, 1);

        // (5+4j) +/- (1)(3+2j)
        send_one(16'h0500, 16'h0400, 16'h0300, 16'h0200, 16'h0100, 16'h0000, 1'b0, 1'b0);
        check_eq("basic_latency", lat, 3);
        check_y("basic", 16'h0800, 16'h0600, 16'h0200, 16'h0200);
        check_eq("basic_ovf", ovf, 0);

        // (-3+0.25j) +/- (0.5+1j)(1+8j) = (-3+0.25j) +/- (-7.5+5j)
        send_one(16'hFD00, 16'h0040, 16'h0100, 16'h0800, 16'h0080, 16'h0100, 1'b0, 1'b0);
        check_y("mixed", 16'hF580, 16'h0540, 16'h0480, 16'hFB40);

        // conj(j)*1 = -j
        send_one(16'h0000, 16'h0000, 16'h0100, 16'h0000, 16'h0000, 16'h0100, 1'b1, 1'b0);
        check_y("inverse", 16'h0000, 16'hFF00, 16'h0000, 16'h0100);

        // (8+6j)/2, (2+2j)/2
        send_one(16'h0500, 16'h0400, 16'h0300, 16'h0200, 16'h0100, 16'h0000, 1'b0, 1'b1);
        check_y("scale", 16'h0400, 16'h0300, 16'h0100, 16'h0100);

        // 1 LSB * 0.5 = 0.5 LSB rounds up to 1 LSB
        send_one(16'h0000, 16'h0000, 16'h0001, 16'h0000, 16'h0080, 16'h0000, 1'b0, 1'b0);
        check_y("round_up", 16'h0001, 16'h0000, 16'hFFFF, 16'h0000);

        // 1 LSB * -0.5 = -0.5 LSB rounds up to 0
        send_one(16'h0000, 16'h0000, 16'h0001, 16'h0000, 16'hFF80, 16'h0000, 1'b0, 1'b0);
        check_y("round_neg", 16'h0000, 16'h0000, 16'h0000, 16'h0000);

        // Halving truncates toward -inf: -1 -> -1, 3 -> 1
        send_one(16'hFFFF, 16'h0003, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b1);
        check_y("scale_trunc", 16'hFFFF, 16'h0001, 16'hFFFF, 16'h0001);

        // Most negative A passes through untouched, no overflow
        send_one(16'h8000, 16'h8000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0);
        check_y("most_neg", 16'h8000, 16'h8000, 16'h8000, 16'h8000);
        check_eq("most_neg_ovf", ovf, 0);

        // 127 + 127 overflows the Q8.8 range
        send_one(16'h7F00, 16'h0000, 16'h7F00, 16'h0000, 16'h0100, 16'h0000, 1'b0, 1'b0);
        check_y("ovf", exp_ovf_re, 16'h0000, 16'h0000, 16'h0000);
        check_eq("ovf_set", ovf, 1);
        repeat (2) @(negedge clk);
        check_eq("ovf_sticky", ovf, 1);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        check_eq("ovf_cleared", ovf, 0);

        // Stream of 5 with consumer back-pressure on cycles 4..7
        acc = 0; got = 0; stalls = 0; stall_prev = 1'b0; prev1 = '0; prev2 = '0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            @(negedge clk);
            out_ready = !(cyc >= 4 && cyc <= 7);
            in_valid  = (acc < 5);
            set_in(16'((acc + 1) << 8), 16'h0, 16'h0100, 16'h0, 16'h0100, 16'h0, 1'b0, 1'b0);
            #1;
            if (out_valid && !out_ready) begin
                stalls++;
                check_eq("stall_in_ready", in_ready, 0);
                if (stall_prev) begin
                    check_eq("stall_hold_y1", y1_re, prev1);
                    check_eq("stall_hold_y2", y2_re, prev2);
                end
                stall_prev = 1'b1;
            end else begin
                stall_prev = 1'b0;
            end
            if (out_valid && out_ready) begin
                if (got < 5) begin
                    check_eq("stream_y1", y1_re, 16'((got + 2) << 8));
                    check_eq("stream_y2", y2_re, 16'(got << 8));
                end
                got++;
            end
            prev1 = y1_re;
            prev2 = y2_re;
            if (in_valid && in_ready) acc++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        check_eq("stream_accepted", acc, 5);
        check_eq("stream_results", got, 5);
        check_eq("stream_stalls", stalls, 4);

        // Reset with an overflowing result at the output and two in flight
        @(negedge clk);
        set_in(16'h7F00, 16'h0000, 16'h7F00, 16'h0000, 16'h0100, 16'h0000, 1'b0, 1'b0);
        in_valid = 1'b1;
        @(negedge clk);
        set_in(16'h0100, 16'h0000, 16'h0100, 16'h0000, 16'h0100, 16'h0000, 1'b0, 1'b0);
        @(negedge clk);
        set_in(16'h0200, 16'h0000, 16'h0100, 16'h0000, 16'h0100, 16'h0000, 1'b0, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check_eq("pre_rst_valid", out_valid, 1);
        check_eq("pre_rst_ovf", ovf, 1);
        #1;
        n_rst = 1'b0;
        #1;
        check_eq("async_rst_valid", out_valid, 0);
        check_eq("async_rst_ovf", ovf, 0);
        check_eq("async_rst_y1re", y1_re, 0);
        check_eq("async_rst_in_ready", in_ready, 1);
        @(negedge clk);
        n_rst = 1'b1;
        stale = 0;
        repeat (6) begin
            @(negedge clk);
            #1;
            if (out_valid) stale++;
        end
        check_eq("no_stale_out", stale, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
